// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/deglitcher.
// Imported by sync_filter_ch and sync_filter_nch.
package sync_filter_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_FILT_LEN    = 1;
  localparam int MIN_CH_NUM      = 1;

  // Counter must hold 0 .. filt_len-1; sized from filt_len+1 so filt_len=1 still yields one bit.
  function automatic int cnt_width(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: N-flop synchronizer followed by a stability filter and edge pulses.
// Edge pulse registers exist only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   C_SYNC_STAGES = 2,
  parameter int   C_FILT_LEN    = 4,
  parameter logic C_RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W   = cnt_width(C_FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_FILT_LEN - 1);

  logic [C_SYNC_STAGES-1:0] sync_p0;
  logic                     sync;
  logic [CNT_W-1:0]         cnt_p1;
  logic                     dout_p1;
  logic                     differ;
  logic                     load;

  // Saturating count of consecutive cycles where sync disagrees with dout.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic            diff);
    if (!diff || cnt == CNT_MAX) begin
      return '0;
    end
    return cnt + CNT_W'(1);
  endfunction

  // Stage p0: synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= {C_SYNC_STAGES{C_RST_VAL}};
    end else begin
      sync_p0 <= {sync_p0[C_SYNC_STAGES-2:0], din};
    end
  end

  assign sync   = sync_p0[C_SYNC_STAGES-1];
  assign differ = (sync != dout_p1);
  assign load   = differ && (cnt_p1 == CNT_MAX);

  // Stage p1: stability filter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1  <= '0;
      dout_p1 <= C_RST_VAL;
    end else begin
      cnt_p1 <= cnt_next(cnt_p1, differ);
      if (load) begin
        dout_p1 <= sync;
      end
    end
  end

  assign dout = dout_p1;

`ifdef SYNC_FILTER_EDGE_EN
  logic rise_p1;
  logic fall_p1;

  // Pulses register on the same edge as dout so they coincide with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      rise_p1 <= load &&  sync;
      fall_p1 <= load && !sync;
    end
  end

  assign rise = rise_p1;
  assign fall = fall_p1;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_nch.sv
// Multi-channel synchronizer + deglitch filter; optional rise/fall pulses
// enabled by defining SYNC_FILTER_EDGE_EN.
module sync_filter_nch
  import sync_filter_pkg::*;
#(
  parameter int                  C_CH_NUM      = 8,
  parameter int                  C_SYNC_STAGES = 2,
  parameter int                  C_FILT_LEN    = 4,
  parameter logic [C_CH_NUM-1:0] C_RST_VAL     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_CH_NUM-1:0] din,
  output logic [C_CH_NUM-1:0] dout,
  output logic [C_CH_NUM-1:0] rise,
  output logic [C_CH_NUM-1:0] fall
);

  if (C_SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("sync_filter_nch: C_SYNC_STAGES must be at least 2");
  end
  if (C_FILT_LEN < MIN_FILT_LEN) begin : g_bad_filt
    $error("sync_filter_nch: C_FILT_LEN must be at least 1");
  end
  if (C_CH_NUM < MIN_CH_NUM) begin : g_bad_ch
    $error("sync_filter_nch: C_CH_NUM must be at least 1");
  end

  for (genvar i = 0; i < C_CH_NUM; i++) begin : g_ch
    sync_filter_ch #(
      .C_SYNC_STAGES (C_SYNC_STAGES),
      .C_FILT_LEN    (C_FILT_LEN),
      .C_RST_VAL     (C_RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filter_nch.sv
// Scoreboard bench for sync_filter_nch (4 channels, 2 sync stages, filter length 4).
module tb_sync_filter_nch;

  localparam int N = 4;
`ifdef SYNC_FILTER_EDGE_EN
  localparam logic [N-1:0] EDGE_MASK = 4'hF;
`else
  localparam logic [N-1:0] EDGE_MASK = 4'h0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] din = '0;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  sync_filter_nch #(
    .C_CH_NUM      (N),
    .C_SYNC_STAGES (2),
    .C_FILT_LEN    (4),
    .C_RST_VAL     (4'h0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dout;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    string        name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   finish_req = 1'b0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one edge's inputs and queue the outputs expected right after that edge.
  task automatic step(input string name, input logic r, input logic [N-1:0] d,
                      input logic [N-1:0] e_dout, input logic [N-1:0] e_rise,
                      input logic [N-1:0] e_fall);
    exp_t e;
    @(negedge clk);
    rst = r;
    din = d;
    e.dout = e_dout;
    e.rise = e_rise & EDGE_MASK;
    e.fall = e_fall & EDGE_MASK;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic hold(input string name, input int n, input logic r,
                      input logic [N-1:0] d, input logic [N-1:0] e_dout);
    for (int i = 0; i < n; i++) step(name, r, d, e_dout, 4'h0, 4'h0);
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      check({e.name, "/dout"}, dout, e.dout);
      check({e.name, "/rise"}, rise, e.rise);
      check({e.name, "/fall"}, fall, e.fall);
    end
    if (finish_req) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    // Reset with all inputs high, then release: nothing may move for 5 edges.
    hold("reset", 3, 1'b1, 4'hF, 4'h0);
    hold("post_reset", 5, 1'b0, 4'hF, 4'h0);
    step("post_reset_rise", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
    hold("all_low", 5, 1'b0, 4'h0, 4'hF);
    step("all_low_fall", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    hold("idle", 3, 1'b0, 4'h0, 4'h0);

    // Held edge on channel 0: dout changes on the 6th edge.
    hold("ch0_hold", 5, 1'b0, 4'h1, 4'h0);
    step("ch0_rise", 1'b0, 4'h1, 4'h1, 4'h1, 4'h0);
    hold("ch0_high", 2, 1'b0, 4'h1, 4'h1);
    hold("ch0_drop", 5, 1'b0, 4'h0, 4'h1);
    step("ch0_fall", 1'b0, 4'h0, 4'h0, 4'h0, 4'h1);
    hold("ch0_low", 2, 1'b0, 4'h0, 4'h0);

    // 3-cycle glitch on channel 1 never reaches dout.
    hold("ch1_glitch", 3, 1'b0, 4'h2, 4'h0);
    hold("ch1_after", 6, 1'b0, 4'h0, 4'h0);

    // Two channels changing together.
    hold("simul_hold", 5, 1'b0, 4'hA, 4'h0);
    step("simul_rise", 1'b0, 4'hA, 4'hA, 4'hA, 4'h0);
    hold("simul_high", 2, 1'b0, 4'hA, 4'hA);
    hold("simul_drop", 5, 1'b0, 4'h0, 4'hA);
    step("simul_fall", 1'b0, 4'h0, 4'h0, 4'h0, 4'hA);
    hold("simul_low", 2, 1'b0, 4'h0, 4'h0);

    // Reset mid-filter on channel 2 discards the partial count.
    hold("mid_partial", 4, 1'b0, 4'h4, 4'h0);
    step("mid_reset", 1'b1, 4'h4, 4'h0, 4'h0, 4'h0);
    hold("mid_refill", 5, 1'b0, 4'h4, 4'h0);
    step("mid_rise", 1'b0, 4'h4, 4'h4, 4'h4, 4'h0);
    hold("mid_drop", 5, 1'b0, 4'h0, 4'h4);
    step("mid_fall", 1'b0, 4'h0, 4'h0, 4'h0, 4'h4);
    hold("mid_low", 2, 1'b0, 4'h0, 4'h0);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    finish_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor: summary not reached, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sync_filter_nch.md
SYNC_FILTER_NCH -- requirements
Module: sync_filter_nch

Interface
REQ-001 SHALL have parameter C_CH_NUM, default 8: number of independent single-bit channels, at least 1.
REQ-002 SHALL have parameter C_SYNC_STAGES, default 2: synchronizer flop depth per channel, at least 2.
REQ-003 SHALL have parameter C_FILT_LEN, default 4: consecutive stable synchronized cycles required before an output changes, at least 1.
REQ-004 SHALL have parameter C_RST_VAL, default all zeros, C_CH_NUM bits: per-channel reset value of dout.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port din, input, C_CH_NUM bits: asynchronous level inputs.
REQ-008 SHALL have port dout, output, C_CH_NUM bits: synchronized, deglitched levels.
REQ-009 SHALL have port rise, output, C_CH_NUM bits: one-cycle pulse when dout[i] goes 0->1.
REQ-010 SHALL have port fall, output, C_CH_NUM bits: one-cycle pulse when dout[i] goes 1->0.

Function
REQ-011 SHALL shift din[i] through a C_SYNC_STAGES-deep flop chain per channel; sync[i] is the last stage.
REQ-012 SHALL keep, per channel, a counter cnt[i] of width $clog2(C_FILT_LEN+1) that saturates at no value beyond C_FILT_LEN-1.
REQ-013 SHALL clear cnt[i] on any edge where sync[i] equals dout[i].
REQ-014 SHALL increment cnt[i] on an edge where sync[i] differs from dout[i] and cnt[i] is below C_FILT_LEN-1.
REQ-015 SHALL load dout[i] with sync[i] and clear cnt[i] on an edge where sync[i] differs from dout[i] and cnt[i] equals C_FILT_LEN-1.
REQ-016 SHALL therefore change dout[i] exactly C_SYNC_STAGES+C_FILT_LEN edges after a held din[i] change is first sampled.
REQ-017 SHALL leave dout[i] and both pulses unchanged for any synchronized excursion shorter than C_FILT_LEN cycles.
REQ-018 SHALL drive rise[i] and fall[i] as registered outputs, high only in the single cycle in which the new dout[i] value is first visible, never both high together.
REQ-019 SHALL treat channels fully independently; simultaneous changes on several channels update in the same cycle.
REQ-020 SHALL with C_FILT_LEN=1 update dout[i] one edge after sync[i] differs.

Reset
REQ-021 SHALL on any edge with rst=1 clear all synchronizer stages to the matching C_RST_VAL bit, set dout to C_RST_VAL, clear every cnt[i], and drive rise=fall=0.
REQ-022 SHALL take reset at the next edge even mid-filter, discarding partial counts, and SHALL emit no pulse on reset entry or exit.

Configuration
REQ-023 SHALL use macro SYNC_FILTER_EDGE_EN: when defined, rise and fall behave per REQ-018; when undefined, rise and fall are tied to constant 0 and their registers are not built.

Structure
REQ-024 SHALL place the counter-width function and the minimum parameter constants (2 sync stages, 1 filter cycle) in shared package sync_filter_pkg.
REQ-025 SHALL implement one channel as sub-module sync_filter_ch, instantiated C_CH_NUM times by a generate loop.
REQ-026 SHALL flag an elaboration error if C_SYNC_STAGES<2, C_FILT_LEN<1 or C_CH_NUM<1.

Verification (C_CH_NUM=4, C_SYNC_STAGES=2, C_FILT_LEN=4, C_RST_VAL=4'h0, macro defined)
REQ-027 SHALL cover reset: rst=1 for 3 cycles with din=4'hF -> dout=4'h0 and rise=fall=0 throughout, with no pulse after release until filtering completes.
REQ-028 SHALL cover a held edge: din[0] 0->1 held -> dout[0]=1 exactly 6 edges later, with rise[0] high for that one cycle only.
REQ-029 SHALL cover a glitch: din[1] high for 3 cycles, then low -> dout[1] stays 0 and rise[1]/fall[1] stay 0.
REQ-030 SHALL cover simultaneous channels: din=4'b1010 at one edge, held -> dout=4'b1010 and rise=4'b1010 in the same cycle; then din=4'h0 -> fall=4'b1010 in the same cycle, 6 edges later.
REQ-031 SHALL cover reset mid-operation: din[2]=1, rst=1 after 4 edges for 1 cycle -> dout[2]=0 and cnt cleared; after release, dout[2]=1 a full 6 edges later.
REQ-032 SHALL cover the macro undefined: the sequence of REQ-028 -> dout timing unchanged and rise=fall=4'h0 always.
